aes_decryptor_ip_buffer: RTL and testbench
==========================================

AES_DECRYPTOR_IP_BUFFER -- requirements
Module: aes_decryptor_ip_buffer

Interface
REQ-001 SHALL have parameter BUF_SIZE, default 8: buffer depth in 16-byte blocks (power of two, >=2).
REQ-002 SHALL have parameter NO_ROWS, default 4: cipher-text matrix rows.
REQ-003 SHALL have parameter NO_COLS, default 4: cipher-text matrix columns (NO_ROWS*NO_COLS=16).
REQ-004 SHALL have port aes_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port ofdm_sdata_vld, input, 1: serial bit valid.
REQ-007 SHALL have port ofdm_sdata_rdy, output, 1: buffer can accept a serial bit.
REQ-008 SHALL have port ofdm_sdata, input, 1: serial cipher-text bit.
REQ-009 SHALL have port cipher_txt_vld, output, 1: a complete block is presented.
REQ-010 SHALL have port cipher_txt_rdy, input, 1: decryptor accepts the block.
REQ-011 SHALL have port aes_cipher_txt, output, [7:0] x [NO_ROWS-1:0][NO_COLS-1:0]: presented block.

Function
REQ-012 SHALL accept a bit on a cycle with ofdm_sdata_vld=1 and ofdm_sdata_rdy=1; bits presented with ofdm_sdata_rdy=0 are ignored.
REQ-013 SHALL assemble bytes LSB first: the first accepted bit of a byte is bit 0, the eighth is bit 7.
REQ-014 SHALL map received byte k (0..15) of a block to aes_cipher_txt[NO_ROWS-1-k/NO_COLS][NO_COLS-1-k%NO_COLS].
REQ-015 SHALL store blocks in a circular memory of 16*BUF_SIZE bytes, with a write block pointer and a read block pointer of log2(BUF_SIZE) bits that wrap modulo BUF_SIZE.
REQ-016 SHALL keep a block count, 0..BUF_SIZE, of completed unread blocks.
REQ-017 SHALL drive ofdm_sdata_rdy = (count < BUF_SIZE) while in RX_IDLE or RX_BYTE, and 0 in RX_FULL.
REQ-018 SHALL implement the receive FSM as follows:
  - RX_IDLE -> RX_BYTE on the first accepted bit of a block.
  - RX_BYTE -> RX_IDLE on the 128th accepted bit when count+1 < BUF_SIZE, or when a pop occurs in the same cycle.
  - RX_BYTE -> RX_FULL on the 128th bit when count+1 = BUF_SIZE and no pop.
  - RX_FULL -> RX_IDLE on a pop.
REQ-019 SHALL assert cipher_txt_vld = (count > 0), registered, first high in the cycle after the 128th bit of a block is accepted into an empty buffer.
REQ-020 SHALL pop on cipher_txt_vld=1 and cipher_txt_rdy=1: read pointer +1 and count -1.
REQ-021 SHALL hold aes_cipher_txt stable at the block addressed by the read pointer while cipher_txt_vld=1 and no pop occurs.
REQ-022 SHALL leave count unchanged when a block completes and a pop occurs in the same cycle; both pointers advance.
REQ-023 SHALL never overwrite an unread block, and never drop or duplicate a block across pointer wrap-around.
REQ-024 SHALL drive aes_cipher_txt with all-zero bytes when cipher_txt_vld=0.

Reset
REQ-025 SHALL, on resetn low, immediately set:
  - ofdm_sdata_rdy=1 and cipher_txt_vld=0;
  - pointers, count, bit counter and byte counter to 0;
  - FSM to RX_IDLE.
REQ-026 SHALL discard any partial byte or block when reset is asserted mid-operation; memory contents need not be cleared.

Configuration
REQ-027 SHALL, when AES_DEC_IP_BUF_STATUS_EN is defined, add:
  - output buf_level [$clog2(BUF_SIZE+1)-1:0], equal to count;
  - output ofdm_overrun, 1 bit, set sticky when ofdm_sdata_vld=1 while ofdm_sdata_rdy=0, and cleared only by reset.
REQ-028 SHALL, when AES_DEC_IP_BUF_STATUS_EN is undefined, omit both ports and their logic; all other behaviour is identical.

Structure
REQ-029 SHALL take byte_t, block_t, BYTES_PER_BLOCK=16 and the RX FSM state enum from shared package aes_buf_pkg.
REQ-030 SHALL instantiate one sub-module, aes_ip_deserializer, containing the bit counter and shift register and emitting a byte plus a one-cycle byte_done strobe.

Verification
REQ-031 SHALL reset the bench, then send 128 bits encoding bytes 0x00..0x0F -> cipher_txt_vld rises the cycle after bit 128, and aes_cipher_txt[3][3]=0x00, [3][2]=0x01, ..., [0][0]=0x0F.
REQ-032 SHALL, with cipher_txt_rdy=0, stream 8 blocks -> ofdm_sdata_rdy=0 after bit 1024 and FSM in RX_FULL; one pop -> ofdm_sdata_rdy=1 on the next cycle.
REQ-033 SHALL push 20 blocks with cipher_txt_rdy random 50% -> 20 blocks popped in order with no loss across two wraps.
REQ-034 SHALL complete block 2 in the same cycle as popping block 1 -> count stays 1 and block 2 is presented next.
REQ-035 SHALL assert resetn low after 70 bits of a block -> outputs return to reset values; the next full 128-bit block is received intact.
REQ-036 SHALL, with AES_DEC_IP_BUF_STATUS_EN defined, drive bit valid while full -> ofdm_overrun=1 and buf_level=8, and ofdm_overrun stays set after pops.

Source files
------------

// File: rtl/aes_buf_pkg.sv
// Shared types for the AES decryptor input buffer: byte/block types,
// block size and the receive FSM state encoding.
package aes_buf_pkg;

  localparam int BYTES_PER_BLOCK = 16;
  localparam int BYTE_IDX_W      = $clog2(BYTES_PER_BLOCK);

  typedef logic [7:0] byte_t;
  typedef byte_t [BYTES_PER_BLOCK-1:0] block_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_BYTE = 2'd1,
    RX_FULL = 2'd2
  } rx_state_e;

endpackage

// File: rtl/aes_ip_deserializer.sv
// Serial-to-byte converter: collects accepted bits LSB first and strobes
// byte_done_o in the same cycle the eighth bit is accepted, with byte_o
// already holding the completed byte so it can be written on that edge.
module aes_ip_deserializer
  import aes_buf_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bit_vld_i,
  input  logic       bit_i,
  output logic [7:0] byte_o,
  output logic       byte_done_o
);

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;

  // Next-state: shift new bit in at the MSB so the first bit ends at bit 0.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (bit_vld_i) begin
      shift_d   = {bit_i, shift_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end else begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
    end
  end

  assign byte_o      = shift_d;
  assign byte_done_o = bit_vld_i && (bit_cnt_q == 3'd7);

  // Bit counter and shift register; reset discards any partial byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

endmodule

// File: rtl/aes_decryptor_ip_buffer.sv
// Circular block buffer between the serial OFDM cipher-text stream and the
// AES decryptor. Bytes are stored per block; complete blocks are presented
// as a NO_ROWS x NO_COLS byte matrix with a valid/ready handshake.
// Optional status ports (buf_level, ofdm_overrun) are built when
// AES_DEC_IP_BUF_STATUS_EN is defined.
module aes_decryptor_ip_buffer
  import aes_buf_pkg::*;
#(
  parameter int BUF_SIZE = 8,
  parameter int NO_ROWS  = 4,
  parameter int NO_COLS  = 4
) (
  input  logic                                  aes_clk,
  input  logic                                  resetn,
  input  logic                                  ofdm_sdata_vld,
  output logic                                  ofdm_sdata_rdy,
  input  logic                                  ofdm_sdata,
  output logic                                  cipher_txt_vld,
  input  logic                                  cipher_txt_rdy,
  output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]  aes_cipher_txt
`ifdef AES_DEC_IP_BUF_STATUS_EN
  ,
  output logic [$clog2(BUF_SIZE+1)-1:0]         buf_level,
  output logic                                  ofdm_overrun
`endif
);

  localparam int PTR_W = $clog2(BUF_SIZE);
  localparam int CNT_W = $clog2(BUF_SIZE + 1);
  localparam int MEM_D = BUF_SIZE * BYTES_PER_BLOCK;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUF_SIZE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  rx_state_e             state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [BYTE_IDX_W-1:0] byte_cnt_q, byte_cnt_d;
  logic                  vld_q;
  byte_t                 mem_q [MEM_D];

  logic   rdy_s;
  logic   accept_s;
  logic   pop_s;
  logic   blk_done_s;
  logic   byte_done_s;
  byte_t  byte_s;
  block_t rd_blk_s;

  aes_ip_deserializer u_deser (
    .clk_i       (aes_clk),
    .rst_ni      (resetn),
    .bit_vld_i   (accept_s),
    .bit_i       (ofdm_sdata),
    .byte_o      (byte_s),
    .byte_done_o (byte_done_s)
  );

  // Ready decode: never accept while full, so unread blocks are never overwritten.
  always_comb begin
    rdy_s = 1'b0;
    if (state_q == RX_FULL) begin
      rdy_s = 1'b0;
    end else begin
      rdy_s = (count_q < CNT_MAX);
    end
  end

  assign ofdm_sdata_rdy = rdy_s;
  assign accept_s       = ofdm_sdata_vld && rdy_s;
  assign pop_s          = vld_q && cipher_txt_rdy;
  assign blk_done_s     = byte_done_s && (byte_cnt_q == BYTE_IDX_W'(BYTES_PER_BLOCK - 1));
  assign cipher_txt_vld = vld_q;

  // Pointer, byte counter and block count next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
    if (byte_done_s) begin
      byte_cnt_d = byte_cnt_q + BYTE_IDX_W'(1);
    end else begin
      byte_cnt_d = byte_cnt_q;
    end
    if (blk_done_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({blk_done_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Receive FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE: begin
        if (accept_s) begin
          state_d = RX_BYTE;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_BYTE: begin
        if (blk_done_s) begin
          if (((count_q + CNT_ONE) < CNT_MAX) || pop_s) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_FULL;
          end
        end else begin
          state_d = RX_BYTE;
        end
      end
      RX_FULL: begin
        if (pop_s) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_FULL;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Control state registers; valid tracks a non-zero next count.
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= RX_IDLE;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      byte_cnt_q <= {BYTE_IDX_W{1'b0}};
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      byte_cnt_q <= byte_cnt_d;
      vld_q      <= (count_d != {CNT_W{1'b0}});
    end
  end

  // Block storage; contents are not cleared by reset.
  always_ff @(posedge aes_clk) begin
    if (byte_done_s) begin
      mem_q[{wr_ptr_q, byte_cnt_q}] <= byte_s;
    end
  end

  // Gather the block addressed by the read pointer.
  always_comb begin
    for (int k = 0; k < BYTES_PER_BLOCK; k++) begin
      rd_blk_s[k] = mem_q[{rd_ptr_q, BYTE_IDX_W'(k)}];
    end
  end

  // Received byte k lands at row NO_ROWS-1-k/NO_COLS, column NO_COLS-1-k%NO_COLS.
  for (genvar k = 0; k < BYTES_PER_BLOCK; k++) begin : g_map
    localparam int R = NO_ROWS - 1 - (k / NO_COLS);
    localparam int C = NO_COLS - 1 - (k % NO_COLS);
    assign aes_cipher_txt[R][C] = vld_q ? rd_blk_s[k] : 8'h00;
  end

`ifdef AES_DEC_IP_BUF_STATUS_EN
  logic overrun_q;

  // Sticky overrun flag: a bit was offered while the buffer refused it.
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      overrun_q <= 1'b0;
    end else if (ofdm_sdata_vld && !rdy_s) begin
      overrun_q <= 1'b1;
    end
  end

  assign buf_level    = count_q;
  assign ofdm_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_aes_decryptor_ip_buffer.sv
// Directed, self-checking bench for aes_decryptor_ip_buffer (default 8x4x4).
module tb_aes_decryptor_ip_buffer;
  import aes_buf_pkg::*;

  typedef logic [15:0][7:0]      bytes_t;
  typedef logic [3:0][3:0][7:0]  mat_t;
  typedef struct {
    logic [7:0] first;
    logic [7:0] stride;
    logic [7:0] e33;
    logic [7:0] e21;
    logic [7:0] e00;
  } vec_t;

  logic aes_clk = 1'b0;
  logic resetn, ofdm_sdata_vld, ofdm_sdata, cipher_txt_rdy;
  logic ofdm_sdata_rdy, cipher_txt_vld;
  mat_t aes_cipher_txt;
`ifdef AES_DEC_IP_BUF_STATUS_EN
  logic [3:0] buf_level;
  logic       ofdm_overrun;
`endif

  int n_vec = 0;
  int n_err = 0;
  bytes_t sb[$];
  vec_t   vt[5];

  aes_decryptor_ip_buffer #(.BUF_SIZE(8), .NO_ROWS(4), .NO_COLS(4)) dut (
    .aes_clk        (aes_clk),
    .resetn         (resetn),
    .ofdm_sdata_vld (ofdm_sdata_vld),
    .ofdm_sdata_rdy (ofdm_sdata_rdy),
    .ofdm_sdata     (ofdm_sdata),
    .cipher_txt_vld (cipher_txt_vld),
    .cipher_txt_rdy (cipher_txt_rdy),
    .aes_cipher_txt (aes_cipher_txt)
`ifdef AES_DEC_IP_BUF_STATUS_EN
    ,
    .buf_level      (buf_level),
    .ofdm_overrun   (ofdm_overrun)
`endif
  );

  always #5 aes_clk = ~aes_clk;

  function automatic bytes_t mk(input logic [7:0] first, input logic [7:0] stride);
    bytes_t b;
    for (int k = 0; k < 16; k++) b[k] = 8'(first + stride * 8'(k));
    return b;
  endfunction

  // Matrix position (r,c) holds received byte (3-r)*4 + (3-c).
  function automatic mat_t to_mat(input bytes_t b);
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = b[(3 - r) * 4 + (3 - c)];
    return m;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aes_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int t;
    t = 0;
    ofdm_sdata_vld = 1'b0;
    while (!ofdm_sdata_rdy && t < 5000) begin
      step();
      t++;
    end
    if (t >= 5000) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got rdy=0, expected rdy=1 within 5000 cycles");
    end
    ofdm_sdata_vld = 1'b1;
    ofdm_sdata     = b;
    step();
    ofdm_sdata_vld = 1'b0;
  endtask

  task automatic send_bits(input bytes_t b, input int n);
    for (int i = 0; i < n; i++) send_bit(b[i / 8][i % 8]);
  endtask

  task automatic pop1();
    cipher_txt_rdy = 1'b1;
    step();
    cipher_txt_rdy = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges; checks values while asserted.
  task automatic mid_reset(input string nm);
    resetn = 1'b0;
    #1;
    chk({nm, "_rdy"}, 128'(ofdm_sdata_rdy), 128'd1);
    chk({nm, "_vld"}, 128'(cipher_txt_vld), 128'd0);
    chk({nm, "_txt"}, aes_cipher_txt, 128'd0);
    #2;
    resetn = 1'b1;
    step();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bytes_t a, b, c;
    int popped, cyc;

    vt[0] = '{first: 8'h10, stride: 8'h01, e33: 8'h10, e21: 8'h16, e00: 8'h1F};
    vt[1] = '{first: 8'hA5, stride: 8'h11, e33: 8'hA5, e21: 8'h0B, e00: 8'hA4};
    vt[2] = '{first: 8'hFF, stride: 8'hFF, e33: 8'hFF, e21: 8'hF9, e00: 8'hF0};
    vt[3] = '{first: 8'h00, stride: 8'h80, e33: 8'h00, e21: 8'h00, e00: 8'h80};
    vt[4] = '{first: 8'h3C, stride: 8'h00, e33: 8'h3C, e21: 8'h3C, e00: 8'h3C};

    resetn = 1'b0;
    ofdm_sdata_vld = 1'b0;
    ofdm_sdata = 1'b0;
    cipher_txt_rdy = 1'b0;
    #12;
    chk("rst_rdy", 128'(ofdm_sdata_rdy), 128'd1);
    chk("rst_vld", 128'(cipher_txt_vld), 128'd0);
    chk("rst_txt", aes_cipher_txt, 128'd0);
    #1;
    resetn = 1'b1;
    step();

    // Bytes 0x00..0x0F: valid only after the 128th bit.
    a = mk(8'h00, 8'h01);
    send_bits(a, 127);
    chk("first_vld_early", 128'(cipher_txt_vld), 128'd0);
    send_bit(a[15][7]);
    chk("first_vld", 128'(cipher_txt_vld), 128'd1);
    chk("first_33", 128'(aes_cipher_txt[3][3]), 128'h00);
    chk("first_32", 128'(aes_cipher_txt[3][2]), 128'h01);
    chk("first_00", 128'(aes_cipher_txt[0][0]), 128'h0F);
    chk("first_blk", aes_cipher_txt, to_mat(a));
    pop1();
    chk("first_pop_vld", 128'(cipher_txt_vld), 128'd0);

    // Table-driven single blocks.
    for (int v = 0; v < 5; v++) begin
      a = mk(vt[v].first, vt[v].stride);
      send_bits(a, 128);
      chk("vec_vld", 128'(cipher_txt_vld), 128'd1);
      chk("vec_33", 128'(aes_cipher_txt[3][3]), 128'(vt[v].e33));
      chk("vec_21", 128'(aes_cipher_txt[2][1]), 128'(vt[v].e21));
      chk("vec_00", 128'(aes_cipher_txt[0][0]), 128'(vt[v].e00));
      chk("vec_blk", aes_cipher_txt, to_mat(a));
      pop1();
      chk("vec_idle_txt", aes_cipher_txt, 128'd0);
    end

    // Fill all 8 blocks, refuse further bits, then drain in order.
    for (int j = 0; j < 8; j++) begin
      a = mk(8'(j * 16 + 1), 8'h03);
      sb.push_back(a);
      send_bits(a, 128);
      if (j == 6) chk("fill7_rdy", 128'(ofdm_sdata_rdy), 128'd1);
    end
    chk("full_rdy", 128'(ofdm_sdata_rdy), 128'd0);
    chk("full_state", 128'(dut.state_q), 128'(RX_FULL));
    ofdm_sdata_vld = 1'b1;
    ofdm_sdata = 1'b1;
    repeat (5) step();
    ofdm_sdata_vld = 1'b0;
    chk("full_head", aes_cipher_txt, to_mat(sb[0]));
    pop1();
    void'(sb.pop_front());
    chk("full_pop_rdy", 128'(ofdm_sdata_rdy), 128'd1);
    while (sb.size() > 0) begin
      chk("drain_order", aes_cipher_txt, to_mat(sb[0]));
      pop1();
      void'(sb.pop_front());
    end
    chk("drain_vld", 128'(cipher_txt_vld), 128'd0);

    // 20 blocks with random consumer back-pressure across wrap-around.
    popped = 0;
    cyc = 0;
    fork
      begin
        for (int j = 0; j < 20; j++) begin
          bytes_t w;
          w = mk(8'(j * 7 + 32), 8'(j + 1));
          sb.push_back(w);
          send_bits(w, 128);
        end
      end
      begin
        while (popped < 20 && cyc < 20000) begin
          cipher_txt_rdy = 1'($urandom_range(0, 1));
          if (cipher_txt_vld && cipher_txt_rdy) begin
            if (sb.size() == 0) begin
              chk("wrap_extra", 128'(popped), 128'd20);
            end else begin
              chk("wrap_order", aes_cipher_txt, to_mat(sb[0]));
              void'(sb.pop_front());
            end
            popped++;
          end
          step();
          cyc++;
        end
        cipher_txt_rdy = 1'b0;
      end
    join
    chk("wrap_count", 128'(popped), 128'd20);
    chk("wrap_vld", 128'(cipher_txt_vld), 128'd0);

    // Block completes on the same edge that pops the previous one.
    a = mk(8'h50, 8'h01);
    b = mk(8'h90, 8'h02);
    send_bits(a, 128);
    send_bits(b, 127);
    chk("same_head", aes_cipher_txt, to_mat(a));
    cipher_txt_rdy = 1'b1;
    send_bit(b[15][7]);
    cipher_txt_rdy = 1'b0;
    chk("same_count", 128'(dut.count_q), 128'd1);
    chk("same_vld", 128'(cipher_txt_vld), 128'd1);
    chk("same_next", aes_cipher_txt, to_mat(b));
    pop1();
    chk("same_empty", 128'(cipher_txt_vld), 128'd0);

    // Reset after 70 bits of a block with one block already buffered.
    a = mk(8'hC0, 8'h05);
    c = mk(8'h07, 8'h0D);
    send_bits(a, 128);
    send_bits(c, 70);
    mid_reset("midrst");
    chk("midrst_count", 128'(dut.count_q), 128'd0);
    send_bits(c, 128);
    chk("after_rst_vld", 128'(cipher_txt_vld), 128'd1);
    chk("after_rst_blk", aes_cipher_txt, to_mat(c));
    pop1();
    chk("after_rst_pop", 128'(cipher_txt_vld), 128'd0);

`ifdef AES_DEC_IP_BUF_STATUS_EN
    mid_reset("strst");
    chk("ovr_clear", 128'(ofdm_overrun), 128'd0);
    for (int j = 0; j < 8; j++) send_bits(mk(8'(j), 8'h21), 128);
    chk("lvl_full", 128'(buf_level), 128'd8);
    chk("ovr_none", 128'(ofdm_overrun), 128'd0);
    ofdm_sdata_vld = 1'b1;
    repeat (3) step();
    ofdm_sdata_vld = 1'b0;
    chk("ovr_set", 128'(ofdm_overrun), 128'd1);
    pop1();
    pop1();
    chk("ovr_sticky", 128'(ofdm_overrun), 128'd1);
    chk("lvl_after", 128'(buf_level), 128'd6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
